if_fetch_unit: RTL
==================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] SHALL be zero).
REQ-002 SHALL provide ports, one per line:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous assert, active-low.
- freeze  input  1  hazard stall from ID; hold the IF/ID outputs.
- Branch_taken  input  1  branch resolved taken in EXE; redirect and flush.
- Branch_Address  input  32  branch target.
- imem_req  output  1  instruction-memory request, level.
- imem_addr  output  32  fetch address, equal to the internal PC.
- imem_ack  input  1  imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- PC  output  32  registered fetch address+4 of the held instruction; feeds ID PCin.
- Instruction  output  32  registered instruction; feeds ID Instruction.
- valid  output  1  registered; Instruction is real, not a bubble.
- fetch_cnt  output  32  delivered-instruction counter.
- stall_cnt  output  32  stall-cycle counter.

Function
REQ-003 SHALL implement FSM {FETCH, HOLD}: FETCH drives imem_req=1; HOLD drives imem_req=0 and holds one buffered word.
REQ-004 FETCH, imem_ack=1, freeze=0: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH.
REQ-005 FETCH, imem_ack=1, freeze=1: buffer <= imem_rdata; IF/ID unchanged; pc unchanged; go HOLD.
REQ-006 FETCH, imem_ack=0, freeze=0: IF/ID <= bubble {Instruction=0, valid=0}, PC output unchanged; pc unchanged.
REQ-007 FETCH, imem_ack=0, freeze=1: IF/ID unchanged.
REQ-008 HOLD, freeze=1: hold everything. HOLD, freeze=0: IF/ID <= {buffer, pc+4, valid=1}; pc <= pc+4; go FETCH.
REQ-009 Branch_taken=1 SHALL take priority over freeze, imem_ack and state: pc <= {Branch_Address[31:2],2'b00}; IF/ID <= {Instruction=0, PC=0, valid=0}; buffer discarded; go FETCH.
REQ-010 An imem_ack in the same cycle as Branch_taken SHALL be discarded; the target address SHALL appear on imem_addr the next cycle.
REQ-011 With single-cycle memory (ack in the request cycle), throughput SHALL be one instruction per cycle and latency from request to IF/ID output SHALL be one edge.
REQ-012 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-013 imem_addr SHALL equal pc combinationally in all states.

Reset
REQ-014 While rst=0: pc=RESET_PC, state=FETCH, imem_req=0, PC=0, Instruction=0, valid=0, buffer=0, fetch_cnt=0, stall_cnt=0.
REQ-015 imem_req SHALL assert in the first cycle after rst deasserts.
REQ-016 Reset assertion mid-request or in HOLD SHALL drop all pending data immediately, with no partial update.

Configuration
REQ-017 Macro IF_PERF_CNT_EN defined: fetch_cnt SHALL increment on every valid=1 load into IF/ID.
REQ-018 Macro IF_PERF_CNT_EN defined: stall_cnt SHALL increment every cycle with freeze=1 or (FETCH and imem_ack=0).
REQ-019 Macro IF_PERF_CNT_EN defined: both counters SHALL saturate at 32'hFFFF_FFFF; Branch_taken SHALL NOT affect them.
REQ-020 Macro IF_PERF_CNT_EN undefined: fetch_cnt and stall_cnt SHALL be constant 0 and no counter flops SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-021 Reset then single-cycle memory returning addr-as-data for 4 cycles -> Instruction 0,4,8,C; PC 4,8,C,10; valid=1 each cycle.
REQ-022 Fetch at pc=8, ack=1 with freeze=1 for 3 cycles -> outputs held, imem_req=0 for 2 cycles; after freeze drops, Instruction=word@8, PC=C; imem_addr=C.
REQ-023 Branch_taken=1 with Branch_Address=32'h0000_0103 while in HOLD -> next cycle valid=0, Instruction=0, imem_addr=32'h0000_0100; buffered word never emitted.
REQ-024 pc=32'hFFFF_FFFC, ack=1 -> PC=0, imem_addr=0.
REQ-025 Memory acks every 3rd cycle for 9 cycles -> 3 valid loads, 6 bubbles; with IF_PERF_CNT_EN fetch_cnt=3, stall_cnt=6; without it both stay 0.
REQ-026 rst pulsed low mid-HOLD -> all outputs read reset values during the pulse; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives the instruction memory and loads the IF/ID register.
// Optional performance counters are built only when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_Address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        valid,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state, state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] buffer;
    logic        flush;
    logic        ifid_load;
    logic        ifid_from_buffer;
    logic        bubble;
    logic        buffer_capture;
    logic        unused_branch_bits;

    // Branch targets are word aligned, so the low target bits are dropped.
    assign unused_branch_bits = ^Branch_Address[1:0];

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    // Gated by rst so the request drops the moment reset asserts, not at the next edge.
    assign imem_req  = rst && (state == FETCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next       = state;
        flush            = 1'b0;
        ifid_load        = 1'b0;
        ifid_from_buffer = 1'b0;
        bubble           = 1'b0;
        buffer_capture   = 1'b0;
        if (Branch_taken) begin
            flush      = 1'b1;
            state_next = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack && !freeze) begin
                        ifid_load = 1'b1;
                    end else if (imem_ack) begin
                        buffer_capture = 1'b1;
                        state_next     = HOLD;
                    end else if (!freeze) begin
                        bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        ifid_load        = 1'b1;
                        ifid_from_buffer = 1'b1;
                        state_next       = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC_ALIGNED;
            buffer      <= '0;
            PC          <= '0;
            Instruction <= '0;
            valid       <= 1'b0;
        end else if (flush) begin
            pc          <= {Branch_Address[31:2], 2'b00};
            buffer      <= '0;
            PC          <= '0;
            Instruction <= '0;
            valid       <= 1'b0;
        end else begin
            if (buffer_capture) begin
                buffer <= imem_rdata;
            end
            if (ifid_load) begin
                Instruction <= ifid_from_buffer ? buffer : imem_rdata;
                PC          <= pc_plus4;
                valid       <= 1'b1;
                pc          <= pc_plus4;
            end else if (bubble) begin
                Instruction <= '0;
                valid       <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic stall_event;

    // Stalls are counted even in a branch cycle; branches never reset the counters.
    assign stall_event = freeze || (state == FETCH && !imem_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (ifid_load && fetch_cnt != 32'hFFFF_FFFF) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_event && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
